// File: rtl/multicycle_core_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: FSM states,
// ALU operations, opcode/funct encodings and small decode helpers.
package multicycle_core_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMRD,
    S_MEMWR,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // True when the opcode (and funct, for R-type) names a supported instruction
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Maps an R-type funct field onto the ALU operation
  function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
    alu_op_t op;
    op = ALU_ADD;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_core_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Register 0 is hard-wired to zero; writes to it are dropped.
module multicycle_core_regfile #(
  parameter int DATA_SIZE = 32,
  parameter int REG_AW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_AW-1:0]    ra_addr,
  input  logic [REG_AW-1:0]    rb_addr,
  output logic [DATA_SIZE-1:0] ra_data,
  output logic [DATA_SIZE-1:0] rb_data,
  input  logic                 we,
  input  logic [REG_AW-1:0]    w_addr,
  input  logic [DATA_SIZE-1:0] w_data
);

  localparam int NREGS = 2 ** REG_AW;

  logic [DATA_SIZE-1:0] regs [NREGS];

  // Clear every register on reset, otherwise perform the single write
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (w_addr != '0)) begin
      regs[w_addr] <= w_data;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core with a single req/ready memory port.
// Every memory-facing output is registered, so a stalled access keeps
// its request stable until the memory accepts it.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int                DATA_SIZE = 32,
  parameter int                ADDR_W    = 16,
  parameter int                REG_AW    = 5,
  parameter logic [ADDR_W-1:0] PC_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 halted,
  output logic [ADDR_W-1:0]    dbg_pc
);

  localparam logic [ADDR_W+27:0] JMASK = {{ADDR_W{1'b0}}, {28{1'b1}}};

  state_t               state;
  logic [ADDR_W-1:0]    pc;
  logic [31:0]          ir;
  logic [DATA_SIZE-1:0] a_reg, b_reg, mdr, alu_out;

  logic [5:0]           opcode, funct;
  logic [REG_AW-1:0]    rs_addr, rt_addr, rd_addr;
  logic [DATA_SIZE-1:0] rs_data, rt_data, sext_imm, branch_target;
  logic [ADDR_W-1:0]    jump_target;
  logic [DATA_SIZE-1:0] alu_a, alu_b, alu_result;
  alu_op_t              alu_op;
  logic                 rf_we;
  logic [REG_AW-1:0]    rf_waddr;
  logic [DATA_SIZE-1:0] rf_wdata;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] x);
    return {x[ADDR_W-1:2], 2'b00};
  endfunction

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign rs_addr  = ir[21 +: REG_AW];
  assign rt_addr  = ir[16 +: REG_AW];
  assign rd_addr  = ir[11 +: REG_AW];
  assign sext_imm = {{(DATA_SIZE-16){ir[15]}}, ir[15:0]};

  assign branch_target = DATA_SIZE'(pc) + (sext_imm << 2);
  assign jump_target   = ADDR_W'(({28'b0, pc} & ~JMASK) |
                                 {{ADDR_W{1'b0}}, ir[25:0], 2'b00});

  assign alu_a  = a_reg;
  assign alu_b  = (opcode == OP_RTYPE) ? b_reg : sext_imm;
  assign alu_op = (opcode == OP_RTYPE) ? funct_to_alu(funct) : ALU_ADD;

  // ALU: wrap-around arithmetic, slt compares as signed
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = {{(DATA_SIZE-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  assign rf_we    = (state == S_WB);
  assign rf_waddr = (opcode == OP_RTYPE) ? rd_addr : rt_addr;
  assign rf_wdata = (opcode == OP_LW) ? mdr : alu_out;

  multicycle_core_regfile #(
    .DATA_SIZE(DATA_SIZE),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .ra_addr(rs_addr),
    .rb_addr(rt_addr),
    .ra_data(rs_data),
    .rb_data(rt_data),
    .we     (rf_we),
    .w_addr (rf_waddr),
    .w_data (rf_wdata)
  );

  assign dbg_pc = pc;

  // Control FSM and datapath registers; a new request is raised on the
  // same edge that enters its state, so zero-wait accesses take one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= PC_RESET;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      mdr       <= '0;
      alu_out   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_addr(pc);
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata[31:0];
            pc      <= pc + ADDR_W'(4);
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg   <= rs_data;
          b_reg   <= rt_data;
          alu_out <= branch_target;
          if (!is_legal(opcode, funct)) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (opcode == OP_J) begin
            pc       <= jump_target;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_addr(jump_target);
            state    <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE, OP_ADDI: begin
              alu_out <= alu_result;
              state   <= S_WB;
            end
            OP_LW: begin
              alu_out  <= alu_result;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(alu_result[ADDR_W-1:0]);
              state    <= S_MEMRD;
            end
            OP_SW: begin
              alu_out   <= alu_result;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= word_addr(alu_result[ADDR_W-1:0]);
              mem_wdata <= b_reg;
              state     <= S_MEMWR;
            end
            OP_BEQ: begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              if (a_reg == b_reg) begin
                pc       <= alu_out[ADDR_W-1:0];
                mem_addr <= word_addr(alu_out[ADDR_W-1:0]);
              end else begin
                mem_addr <= word_addr(pc);
              end
              state <= S_FETCH;
            end
            default: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
          endcase
        end
        S_MEMRD: begin
          if (mem_ready) begin
            mdr     <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_WB;
          end
        end
        S_MEMWR: begin
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_addr <= word_addr(pc);
            state    <= S_FETCH;
          end
        end
        S_WB: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= word_addr(pc);
          state    <= S_FETCH;
        end
        S_HALT: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end
        default: begin
          halted <= 1'b1;
          state  <= S_HALT;
        end
      endcase
    end
  end

endmodule
